// File: rtl/axis_pair_adder.sv
// Pairs operand beats from two NoC source tiles in arrival order and emits their
// OPW-bit sum as a single-beat AXI-Stream packet toward the output tile.

module axis_pair_fifo #(
    parameter int W     = 30,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module axis_pair_adder #(
    parameter int TDATAW     = 32,
    parameter int TDESTW     = 4,
    parameter int TIDW       = 2,
    parameter int SRC_A_ID   = 0,
    parameter int SRC_B_ID   = 2,
    parameter int OWN_ID     = 1,
    parameter int OUT_DEST   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TDESTW-1:0] AXIS_M_TDEST
);
    localparam int OPW = TDATAW - TIDW;

    logic [TIDW-1:0] in_id;
    logic            is_a;
    logic            is_b;
    logic            push_a;
    logic            push_b;
    logic            pop;
    logic            empty_a;
    logic            empty_b;
    logic            full_a;
    logic            full_b;
    logic [OPW-1:0]  head_a;
    logic [OPW-1:0]  head_b;
    logic [OPW-1:0]  sum;

    // Every beat is a standalone operand, so framing and routing fields carry nothing here.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, AXIS_S_TLAST, AXIS_S_TDEST};

    assign in_id = AXIS_S_TDATA[TDATAW-1 -: TIDW];
    assign is_a  = (in_id == TIDW'(SRC_A_ID));
    assign is_b  = (in_id == TIDW'(SRC_B_ID));

    // Ready looks only at the source ID and FIFO fill, keeping the master side off this path.
    always_comb begin
        AXIS_S_TREADY = 1'b1;
        if (is_a)      AXIS_S_TREADY = !full_a;
        else if (is_b) AXIS_S_TREADY = !full_b;
    end

    assign push_a = AXIS_S_TVALID && is_a && !full_a;
    assign push_b = AXIS_S_TVALID && is_b && !full_b;
    assign pop    = !empty_a && !empty_b && (!AXIS_M_TVALID || AXIS_M_TREADY);
    assign sum    = head_a + head_b;

    axis_pair_fifo #(.W(OPW), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk   (CLK),
        .rst   (RST),
        .push  (push_a),
        .pop   (pop),
        .din   (AXIS_S_TDATA[OPW-1:0]),
        .dout  (head_a),
        .empty (empty_a),
        .full  (full_a)
    );

    axis_pair_fifo #(.W(OPW), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk   (CLK),
        .rst   (RST),
        .push  (push_b),
        .pop   (pop),
        .din   (AXIS_S_TDATA[OPW-1:0]),
        .dout  (head_b),
        .empty (empty_b),
        .full  (full_b)
    );

    // Output register: reloads on a pop, otherwise clears once the NoC takes the beat.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AXIS_M_TVALID <= 1'b0;
            AXIS_M_TDATA  <= '0;
            AXIS_M_TDEST  <= '0;
            AXIS_M_TLAST  <= 1'b0;
        end else if (pop) begin
            AXIS_M_TVALID <= 1'b1;
            AXIS_M_TDATA  <= {TIDW'(OWN_ID), sum};
            AXIS_M_TDEST  <= TDESTW'(OUT_DEST);
            AXIS_M_TLAST  <= 1'b1;
        end else if (AXIS_M_TREADY) begin
            AXIS_M_TVALID <= 1'b0;
            AXIS_M_TDATA  <= '0;
            AXIS_M_TDEST  <= '0;
            AXIS_M_TLAST  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_pair_adder.sv
// Directed-vector bench for axis_pair_adder: reset, pairing, ordering/wrap, bad ID,
// backpressure with full FIFOs, and reset flush in the middle of traffic.

module tb_axis_pair_adder;
    localparam int TDATAW = 32;
    localparam int TDESTW = 4;
    localparam int TIDW   = 2;
    localparam int OPW    = TDATAW - TIDW;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              AXIS_S_TVALID = 1'b0;
    logic              AXIS_S_TREADY;
    logic [TDATAW-1:0] AXIS_S_TDATA = '0;
    logic              AXIS_S_TLAST = 1'b1;
    logic [TDESTW-1:0] AXIS_S_TDEST = 4'd1;
    logic              AXIS_M_TVALID;
    logic              AXIS_M_TREADY = 1'b1;
    logic [TDATAW-1:0] AXIS_M_TDATA;
    logic              AXIS_M_TLAST;
    logic [TDESTW-1:0] AXIS_M_TDEST;

    axis_pair_adder dut (
        .CLK           (CLK),
        .RST           (RST),
        .AXIS_S_TVALID (AXIS_S_TVALID),
        .AXIS_S_TREADY (AXIS_S_TREADY),
        .AXIS_S_TDATA  (AXIS_S_TDATA),
        .AXIS_S_TLAST  (AXIS_S_TLAST),
        .AXIS_S_TDEST  (AXIS_S_TDEST),
        .AXIS_M_TVALID (AXIS_M_TVALID),
        .AXIS_M_TREADY (AXIS_M_TREADY),
        .AXIS_M_TDATA  (AXIS_M_TDATA),
        .AXIS_M_TLAST  (AXIS_M_TLAST),
        .AXIS_M_TDEST  (AXIS_M_TDEST)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected result beat: OWN_ID=1 in the top bits, sum in the low 30.
    function automatic logic [TDATAW-1:0] res(input int s);
        logic [OPW-1:0] v;
        v = OPW'(s);
        return {2'd1, v};
    endfunction

    // Monitor: collects delivered beats and checks hold-stability under backpressure.
    logic [TDATAW-1:0] got_q[$];
    logic [TDATAW-1:0] hold_data;
    bit                stalled = 0;

    always @(negedge CLK) begin
        if (RST) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check("hold_valid", 64'(AXIS_M_TVALID), 64'd1);
                check("hold_data", 64'(AXIS_M_TDATA), 64'(hold_data));
            end
            if (AXIS_M_TVALID) begin
                check("tdest", 64'(AXIS_M_TDEST), 64'd3);
                check("tlast", 64'(AXIS_M_TLAST), 64'd1);
            end
            if (AXIS_M_TVALID && AXIS_M_TREADY) got_q.push_back(AXIS_M_TDATA);
            stalled   = AXIS_M_TVALID && !AXIS_M_TREADY;
            hold_data = AXIS_M_TDATA;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives one beat from posedge+1 and returns at posedge+1 after it is accepted.
    task automatic send(input int id, input int val);
        int cyc;
        logic [TIDW-1:0] idv;
        logic [OPW-1:0]  opv;
        cyc = 0;
        idv = TIDW'(id);
        opv = OPW'(val);
        AXIS_S_TDATA  = {idv, opv};
        AXIS_S_TVALID = 1'b1;
        forever begin
            @(negedge CLK);
            if (AXIS_S_TREADY) break;
            cyc++;
            if (cyc > 50) begin
                check("send_timeout", 64'd0, 64'd1);
                AXIS_S_TVALID = 1'b0;
                return;
            end
        end
        @(posedge CLK);
        #1;
        AXIS_S_TVALID = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int cyc;
        cyc = 0;
        while (got_q.size() < n && cyc < 100) begin
            step(1);
            cyc++;
        end
        check("result_count", 64'(got_q.size()), 64'(n));
    endtask

    task automatic probe_ready(input string tag, input int id, input logic exp);
        logic [TIDW-1:0] idv;
        idv = TIDW'(id);
        AXIS_S_TDATA = {idv, 30'h0};
        #1;
        check(tag, 64'(AXIS_S_TREADY), 64'(exp));
    endtask

    initial begin
        // Reset state
        AXIS_S_TDATA = 32'h0000_0000;
        #12;
        check("rst_m_tvalid", 64'(AXIS_M_TVALID), 64'd0);
        check("rst_s_tready", 64'(AXIS_S_TREADY), 64'd1);
        check("rst_m_tdata", 64'(AXIS_M_TDATA), 64'd0);
        check("rst_m_tdest", 64'(AXIS_M_TDEST), 64'd0);
        check("rst_m_tlast", 64'(AXIS_M_TLAST), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        step(4);
        check("idle_no_valid", 64'(AXIS_M_TVALID), 64'd0);
        check("idle_no_result", 64'(got_q.size()), 64'd0);

        // Single pair with latency check
        send(0, 32'h05);
        send(2, 32'h10);
        @(negedge CLK);
        check("lat_edge_n", 64'(AXIS_M_TVALID), 64'd0);
        @(negedge CLK);
        check("lat_edge_n1", 64'(AXIS_M_TVALID), 64'd1);
        check("pair_tdata", 64'(AXIS_M_TDATA), 64'h4000_0015);
        step(3);
        check("pair_count", 64'(got_q.size()), 64'd1);
        check("pair_result", 64'(got_q[0]), 64'(res(32'h15)));
        check("pair_one_beat", 64'(AXIS_M_TVALID), 64'd0);
        got_q.delete();

        // Ordering and modular wrap
        send(0, 1);
        send(0, 2);
        send(0, 3);
        send(2, 10);
        send(2, 20);
        send(2, 32'h3FFF_FFFF);
        wait_results(3);
        step(4);
        check("order_count", 64'(got_q.size()), 64'd3);
        check("order_0", 64'(got_q[0]), 64'(res(11)));
        check("order_1", 64'(got_q[1]), 64'(res(22)));
        check("order_2_wrap", 64'(got_q[2]), 64'h4000_0002);
        got_q.delete();

        // Bad ID is accepted and dropped
        probe_ready("bad_id_ready", 3, 1'b1);
        send(3, 32'h77);
        step(4);
        check("bad_id_no_result", 64'(got_q.size()), 64'd0);
        send(0, 7);
        send(2, 8);
        wait_results(1);
        step(3);
        check("bad_id_clean_count", 64'(got_q.size()), 64'd1);
        check("bad_id_clean_sum", 64'(got_q[0]), 64'(res(15)));
        got_q.delete();

        // Backpressure: one result held, both FIFOs full
        AXIS_M_TREADY = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(0, i);
            send(2, 10 * i);
        end
        step(3);
        @(negedge CLK);
        check("bp_valid", 64'(AXIS_M_TVALID), 64'd1);
        check("bp_head", 64'(AXIS_M_TDATA), 64'(res(11)));
        step(1);
        probe_ready("bp_ready_a", 0, 1'b0);
        probe_ready("bp_ready_b", 2, 1'b0);
        probe_ready("bp_ready_other", 3, 1'b1);
        check("bp_none_delivered", 64'(got_q.size()), 64'd0);
        AXIS_M_TREADY = 1'b1;
        wait_results(5);
        step(4);
        check("bp_total", 64'(got_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size())
                check($sformatf("bp_sum_%0d", i), 64'(got_q[i]), 64'(res(11 * (i + 1))));
        end
        got_q.delete();

        // Reset mid-operation flushes pending result and queued operands
        AXIS_M_TREADY = 1'b0;
        send(0, 1);
        send(2, 2);
        send(0, 4);
        send(0, 5);
        step(2);
        check("mid_pending", 64'(AXIS_M_TVALID), 64'd1);
        RST = 1'b1;
        #1;
        check("mid_rst_valid", 64'(AXIS_M_TVALID), 64'd0);
        check("mid_rst_tdata", 64'(AXIS_M_TDATA), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        AXIS_M_TREADY = 1'b1;
        send(2, 6);
        send(2, 7);
        step(10);
        check("mid_b_only_none", 64'(got_q.size()), 64'd0);
        check("mid_b_only_valid", 64'(AXIS_M_TVALID), 64'd0);
        send(0, 9);
        wait_results(1);
        step(3);
        check("mid_post_count", 64'(got_q.size()), 64'd1);
        check("mid_post_sum", 64'(got_q[0]), 64'(res(15)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
